// File: rtl/regfile_fwd_pkg.sv
// Shared constants and types for the forwarding register file.
package regfile_fwd_pkg;

    localparam int unsigned DEF_DATA_W = 16;
    localparam int unsigned DEF_ADDR_W = 3;

    typedef logic [DEF_ADDR_W-1:0] reg_addr_t;
    typedef logic [DEF_DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/regfile_read_port.sv
// One read port: write-data bypass, reset masking, zero-register masking and busy lookup.
module regfile_read_port
    import regfile_fwd_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter bit          ZERO_REG = 1'b0,
    parameter bit          BYPASS   = 1'b1
) (
    input  logic              reset_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] stored_data_i,
    input  logic              stored_busy_i,
    input  logic              we0_i,
    input  logic [ADDR_W-1:0] addr_w0_i,
    input  logic [DATA_W-1:0] data_w0_i,
    input  logic              we1_i,
    input  logic [ADDR_W-1:0] addr_w1_i,
    input  logic [DATA_W-1:0] data_w1_i,
    output logic [DATA_W-1:0] data_o,
    output logic              busy_o
);

    logic is_zero_reg;

    assign is_zero_reg = ZERO_REG && (addr_i == '0);

    always_comb begin
        data_o = stored_data_i;
        // Port 1 is checked first so it wins when both writers target this address.
        if (BYPASS) begin
            if (we1_i && (addr_w1_i == addr_i)) begin
                data_o = data_w1_i;
            end else if (we0_i && (addr_w0_i == addr_i)) begin
                data_o = data_w0_i;
            end
        end
        if (reset_i || is_zero_reg) begin
            data_o = '0;
        end
    end

    assign busy_o = stored_busy_i && !is_zero_reg;

endmodule

// File: rtl/regfile_fwd.sv
// Two-write, two-read register file with same-cycle write forwarding and per-register busy tracking.
module regfile_fwd
    import regfile_fwd_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter bit          ZERO_REG = 1'b0,
    parameter bit          BYPASS   = 1'b1,
    localparam int unsigned DEPTH   = 1 << ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr_w0,
    input  logic [DATA_W-1:0] data_w0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr_w1,
    input  logic [DATA_W-1:0] data_w1,
    input  logic [ADDR_W-1:0] addrA,
    input  logic [ADDR_W-1:0] addrB,
    output logic [DATA_W-1:0] dataA,
    output logic [DATA_W-1:0] dataB,
    input  logic              set_busy,
    input  logic [ADDR_W-1:0] addr_busy,
    output logic              busyA,
    output logic              busyB,
    output logic [DEPTH-1:0]  busy_vec
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;
    logic              wen0;
    logic              wen1;
    logic              set_ok;

    // Register 0 is hard-wired when ZERO_REG is set, so its writes and busy sets are dropped here.
    assign wen0   = we0      && !(ZERO_REG && (addr_w0   == '0));
    assign wen1   = we1      && !(ZERO_REG && (addr_w1   == '0));
    assign set_ok = set_busy && !(ZERO_REG && (addr_busy == '0));

    always_comb begin
        mem_d = mem_q;
        if (wen0) begin
            mem_d[addr_w0] = data_w0;
        end
        if (wen1) begin
            mem_d[addr_w1] = data_w1;
        end
    end

    always_comb begin
        busy_d = busy_q;
        if (wen0) begin
            busy_d[addr_w0] = 1'b0;
        end
        if (wen1) begin
            busy_d[addr_w1] = 1'b0;
        end
        // A set after the clears lets a new pending producer override a completing write.
        if (set_ok) begin
            busy_d[addr_busy] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_vec = busy_q;

    regfile_read_port #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG),
        .BYPASS   (BYPASS)
    ) u_port_a (
        .reset_i       (reset),
        .addr_i        (addrA),
        .stored_data_i (mem_q[addrA]),
        .stored_busy_i (busy_q[addrA]),
        .we0_i         (we0),
        .addr_w0_i     (addr_w0),
        .data_w0_i     (data_w0),
        .we1_i         (we1),
        .addr_w1_i     (addr_w1),
        .data_w1_i     (data_w1),
        .data_o        (dataA),
        .busy_o        (busyA)
    );

    regfile_read_port #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG),
        .BYPASS   (BYPASS)
    ) u_port_b (
        .reset_i       (reset),
        .addr_i        (addrB),
        .stored_data_i (mem_q[addrB]),
        .stored_busy_i (busy_q[addrB]),
        .we0_i         (we0),
        .addr_w0_i     (addr_w0),
        .data_w0_i     (data_w0),
        .we1_i         (we1),
        .addr_w1_i     (addr_w1),
        .data_w1_i     (data_w1),
        .data_o        (dataB),
        .busy_o        (busyB)
    );

endmodule

// File: tb/tb_regfile_fwd.sv
// Directed bench for regfile_fwd: default, no-bypass and zero-register configurations share one stimulus.
module tb_regfile_fwd;
    import regfile_fwd_pkg::*;

    logic      clk;
    logic      reset;
    logic      we0, we1, set_busy;
    reg_addr_t addr_w0, addr_w1, addrA, addrB, addr_busy;
    reg_data_t data_w0, data_w1;

    reg_data_t d_dataA, d_dataB, n_dataA, n_dataB, z_dataA, z_dataB;
    logic      d_busyA, d_busyB, n_busyA, n_busyB, z_busyA, z_busyB;
    logic [7:0] d_bvec, n_bvec, z_bvec;

    int unsigned n_checks;
    int unsigned n_fail;

    regfile_fwd #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1'b0), .BYPASS(1'b1)) u_def (
        .clk(clk), .reset(reset),
        .we0(we0), .addr_w0(addr_w0), .data_w0(data_w0),
        .we1(we1), .addr_w1(addr_w1), .data_w1(data_w1),
        .addrA(addrA), .addrB(addrB), .dataA(d_dataA), .dataB(d_dataB),
        .set_busy(set_busy), .addr_busy(addr_busy),
        .busyA(d_busyA), .busyB(d_busyB), .busy_vec(d_bvec)
    );

    regfile_fwd #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1'b0), .BYPASS(1'b0)) u_nob (
        .clk(clk), .reset(reset),
        .we0(we0), .addr_w0(addr_w0), .data_w0(data_w0),
        .we1(we1), .addr_w1(addr_w1), .data_w1(data_w1),
        .addrA(addrA), .addrB(addrB), .dataA(n_dataA), .dataB(n_dataB),
        .set_busy(set_busy), .addr_busy(addr_busy),
        .busyA(n_busyA), .busyB(n_busyB), .busy_vec(n_bvec)
    );

    regfile_fwd #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1'b1), .BYPASS(1'b1)) u_zr (
        .clk(clk), .reset(reset),
        .we0(we0), .addr_w0(addr_w0), .data_w0(data_w0),
        .we1(we1), .addr_w1(addr_w1), .data_w1(data_w1),
        .addrA(addrA), .addrB(addrB), .dataA(z_dataA), .dataB(z_dataB),
        .set_busy(set_busy), .addr_busy(addr_busy),
        .busyA(z_busyA), .busyB(z_busyB), .busy_vec(z_bvec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle();
        we0 = 1'b0; we1 = 1'b0; set_busy = 1'b0;
        addr_w0 = '0; addr_w1 = '0; addr_busy = '0;
        data_w0 = '0; data_w1 = '0;
    endtask

    // Inputs change on the falling edge; combinational checks follow #1 later.
    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        idle();
        reset = 1'b1;
        addrA = '0;
        addrB = 3'd7;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_dataA", d_dataA, 16'h0000);
        check("rst_dataB", d_dataB, 16'h0000);
        check("rst_busyA", d_busyA, 1'b0);
        check("rst_busyB", d_busyB, 1'b0);
        check("rst_bvec",  d_bvec,  8'h00);
        check("rst_bvec_zr", z_bvec, 8'h00);

        // Fill every register via port 0, observing forwarding on port B during the write.
        for (int i = 0; i < 8; i++) begin
            we0 = 1'b1;
            addr_w0 = 3'(i);
            data_w0 = 16'h1000 + 16'(i);
            addrB = 3'(i);
            #1;
            check($sformatf("fwd_def_B%0d", i), d_dataB, 16'h1000 + 16'(i));
            check($sformatf("fwd_nob_B%0d", i), n_dataB, 16'h0000);
            check($sformatf("fwd_zr_B%0d", i),  z_dataB, (i == 0) ? 16'h0000 : 16'h1000 + 16'(i));
            next_cycle();
            idle();
            addrA = 3'(i);
            #1;
            check($sformatf("rd_def_A%0d", i), d_dataA, 16'h1000 + 16'(i));
            check($sformatf("rd_nob_A%0d", i), n_dataA, 16'h1000 + 16'(i));
            check($sformatf("rd_zr_A%0d", i),  z_dataA, (i == 0) ? 16'h0000 : 16'h1000 + 16'(i));
        end

        // Both ports hit reg3 in the same cycle: port 1 wins.
        we0 = 1'b1; addr_w0 = 3'd3; data_w0 = 16'hAAAA;
        we1 = 1'b1; addr_w1 = 3'd3; data_w1 = 16'hBBBB;
        addrA = 3'd3;
        #1;
        check("same_def_fwd", d_dataA, 16'hBBBB);
        check("same_nob_old", n_dataA, 16'h1003);
        next_cycle();
        idle();
        #1;
        check("same_def_st", d_dataA, 16'hBBBB);
        check("same_nob_st", n_dataA, 16'hBBBB);

        // Distinct addresses on the two write ports, both forwarded.
        we0 = 1'b1; addr_w0 = 3'd4; data_w0 = 16'h4444;
        we1 = 1'b1; addr_w1 = 3'd6; data_w1 = 16'h6666;
        addrA = 3'd4; addrB = 3'd6;
        #1;
        check("dual_def_A", d_dataA, 16'h4444);
        check("dual_def_B", d_dataB, 16'h6666);
        check("dual_nob_A", n_dataA, 16'h1004);
        next_cycle();
        idle();
        #1;
        check("dual_nob_stA", n_dataA, 16'h4444);
        check("dual_nob_stB", n_dataB, 16'h6666);

        // Busy set on reg5, then write+set (set wins), then plain write clears.
        set_busy = 1'b1; addr_busy = 3'd5; addrA = 3'd5;
        #1;
        check("busy_nofwd", d_busyA, 1'b0);
        next_cycle();
        idle();
        #1;
        check("busy_set_A", d_busyA, 1'b1);
        check("busy_set_vec", d_bvec, 8'h20);
        we0 = 1'b1; addr_w0 = 3'd5; data_w0 = 16'h1234;
        set_busy = 1'b1; addr_busy = 3'd5;
        next_cycle();
        idle();
        #1;
        check("busy_setwins_A", d_busyA, 1'b1);
        check("busy_setwins_d", d_dataA, 16'h1234);
        we1 = 1'b1; addr_w1 = 3'd5; data_w1 = 16'h5678;
        next_cycle();
        idle();
        #1;
        check("busy_clr_A", d_busyA, 1'b0);
        check("busy_clr_d", d_dataA, 16'h5678);
        check("busy_clr_vec", d_bvec, 8'h00);

        // Register 0 write and busy set: ignored only when ZERO_REG is set.
        we0 = 1'b1; addr_w0 = 3'd0; data_w0 = 16'hDEAD;
        set_busy = 1'b1; addr_busy = 3'd0; addrA = 3'd0;
        #1;
        check("zr_fwd_zr", z_dataA, 16'h0000);
        check("zr_fwd_def", d_dataA, 16'hDEAD);
        next_cycle();
        idle();
        #1;
        check("zr_data", z_dataA, 16'h0000);
        check("zr_busyA", z_busyA, 1'b0);
        check("zr_bvec", z_bvec, 8'h00);
        check("zr_def_data", d_dataA, 16'hDEAD);
        check("zr_def_busy", d_busyA, 1'b1);
        check("zr_def_bvec", d_bvec, 8'h01);

        // Reset beats a simultaneous write and busy set.
        reset = 1'b1;
        we0 = 1'b1; addr_w0 = 3'd2; data_w0 = 16'h5555;
        set_busy = 1'b1; addr_busy = 3'd6;
        addrA = 3'd2; addrB = 3'd3;
        #1;
        check("rstw_fwd_sup", d_dataA, 16'h0000);
        check("rstw_rd_zero", d_dataB, 16'h0000);
        next_cycle();
        reset = 1'b0;
        idle();
        addr_w0 = 3'd3; data_w0 = 16'hDEAD;
        #1;
        check("rstw_reg2", d_dataA, 16'h0000);
        check("rstw_bvec", d_bvec, 8'h00);
        next_cycle();
        idle();
        #1;
        check("rstw_reg3_def", d_dataB, 16'h0000);
        check("rstw_reg3_nob", n_dataB, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
